// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD register and its digit cell:
// the operation codes, the digit width and the digit-validity helpers.
package bcd_pkg;

  localparam int BCD_W = 4;

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_CLEAR = 3'd2;
  localparam logic [2:0] MODE_SHL   = 3'd3;
  localparam logic [2:0] MODE_SHR   = 3'd4;
  localparam logic [2:0] MODE_INC   = 3'd5;
  localparam logic [2:0] MODE_DEC   = 3'd6;
  localparam logic [2:0] MODE_RSVD  = 3'd7;

  // A nibble is a legal BCD digit when it is 0..9.
  function automatic logic is_bcd_digit(input logic [BCD_W-1:0] d);
    return (d <= 4'd9);
  endfunction

  // Elaboration-time check that the lowest 'digits' nibbles of v are all BCD.
  function automatic bit all_bcd(input logic [31:0] v, input int digits);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < digits; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the increment/decrement ripple chain. With i_cin=0 the
// digit passes through untouched; with i_cin=1 it steps by one in the
// direction chosen by i_inc and reports a wrap on o_cout.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  input  logic             i_inc,
  input  logic             i_cin,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_cout
);

  // Step the digit when the carry/borrow from below reaches it.
  always_comb begin
    o_digit = i_digit;
    o_cout  = 1'b0;
    if (i_cin) begin
      if (i_inc) begin
        if (i_digit == 4'd9) begin
          o_digit = 4'd0;
          o_cout  = 1'b1;
        end else begin
          o_digit = i_digit + 4'd1;
        end
      end else begin
        if (i_digit == 4'd0) begin
          o_digit = 4'd9;
          o_cout  = 1'b1;
        end else begin
          o_digit = i_digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_reg_n.sv
// N-digit packed-BCD register: hold, guarded load, clear, digit shifts with
// serial in/out, and BCD increment/decrement with a one-cycle wrap pulse.
// Loads and shifts are validated so Q only ever contains legal BCD digits;
// rejected inputs raise a sticky err that only CLEAR or rst removes.
module bcd_reg_n
  import bcd_pkg::*;
#(
  parameter int                  DIGITS    = 3,
  parameter logic [4*DIGITS-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [2:0]          mode,
  input  logic [4*DIGITS-1:0] D,
  input  logic [BCD_W-1:0]    din_digit,
  output logic [4*DIGITS-1:0] Q,
  output logic [BCD_W-1:0]    shift_out,
  output logic                carry,
  output logic                err
);

  localparam int W = 4 * DIGITS;

  if ((DIGITS < 1) || (DIGITS > 8)) begin : g_bad_digits
    $fatal(1, "bcd_reg_n: DIGITS must be 1..8");
  end

  if (!all_bcd(32'(RESET_VAL), DIGITS)) begin : g_bad_reset
    $fatal(1, "bcd_reg_n: RESET_VAL contains a non-BCD nibble");
  end

  logic [W-1:0]       r_q;
  logic [BCD_W-1:0]   r_shift_out;
  logic               r_carry;
  logic               r_err;

  logic [W-1:0]       w_nxt_q;
  logic [BCD_W-1:0]   w_nxt_shift_out;
  logic               w_nxt_carry;
  logic               w_nxt_err;

  logic               w_load_ok;
  logic               w_din_ok;
  logic               w_inc;
  logic [W-1:0]       w_shl_q;
  logic [W-1:0]       w_shr_q;
  logic [W-1:0]       w_step_q;
  logic [DIGITS:0]    w_chain;

  assign w_din_ok = is_bcd_digit(din_digit);
  assign w_inc    = (mode == MODE_INC);

  // Parallel load is accepted only if every nibble of D is a BCD digit.
  always_comb begin
    w_load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(D[4*i +: 4])) w_load_ok = 1'b0;
    end
  end

  // With a single digit both shifts simply replace that digit.
  if (DIGITS == 1) begin : g_shift_one
    assign w_shl_q = din_digit;
    assign w_shr_q = din_digit;
  end else begin : g_shift_many
    assign w_shl_q = {r_q[W-5:0], din_digit};
    assign w_shr_q = {din_digit, r_q[W-1:4]};
  end

  // Ripple chain: the least significant digit always receives the +/-1, and
  // a carry out of the top digit means the whole register wrapped.
  assign w_chain[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_digit_cell u_cell (
      .i_digit (r_q[4*g +: 4]),
      .i_inc   (w_inc),
      .i_cin   (w_chain[g]),
      .o_digit (w_step_q[4*g +: 4]),
      .o_cout  (w_chain[g+1])
    );
  end

  // Next-state selection: en=0 holds everything except carry, which is
  // recomputed every edge and only set by a wrapping INC/DEC.
  always_comb begin
    w_nxt_q         = r_q;
    w_nxt_shift_out = r_shift_out;
    w_nxt_carry     = 1'b0;
    w_nxt_err       = r_err;
    if (en) begin
      case (mode)
        MODE_LOAD: begin
          if (w_load_ok) w_nxt_q   = D;
          else           w_nxt_err = 1'b1;
        end
        MODE_CLEAR: begin
          w_nxt_q   = RESET_VAL;
          w_nxt_err = 1'b0;
        end
        MODE_SHL: begin
          if (w_din_ok) begin
            w_nxt_q         = w_shl_q;
            w_nxt_shift_out = r_q[W-1 -: 4];
          end else begin
            w_nxt_err = 1'b1;
          end
        end
        MODE_SHR: begin
          if (w_din_ok) begin
            w_nxt_q         = w_shr_q;
            w_nxt_shift_out = r_q[3:0];
          end else begin
            w_nxt_err = 1'b1;
          end
        end
        MODE_INC, MODE_DEC: begin
          w_nxt_q     = w_step_q;
          w_nxt_carry = w_chain[DIGITS];
        end
        default: begin
          // HOLD and the reserved code leave everything as it is.
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q         <= RESET_VAL;
      r_shift_out <= '0;
      r_carry     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_q         <= w_nxt_q;
      r_shift_out <= w_nxt_shift_out;
      r_carry     <= w_nxt_carry;
      r_err       <= w_nxt_err;
    end
  end

  assign Q         = r_q;
  assign shift_out = r_shift_out;
  assign carry     = r_carry;
  assign err       = r_err;

endmodule

// File: tb/tb_bcd_reg_n.sv
// Directed bench for bcd_reg_n with DIGITS=3: a table of one-cycle vectors
// applied in order, then hand-written asynchronous-reset sequences.
module tb_bcd_reg_n;
  import bcd_pkg::*;

  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;
  localparam int EW     = W + 4 + 1 + 1;

  logic          clk;
  logic          rst;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic [3:0]    din_digit;
  logic [W-1:0]  q;
  logic [3:0]    shift_out;
  logic          carry;
  logic          err;

  bcd_reg_n #(
    .DIGITS    (DIGITS),
    .RESET_VAL (12'h000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .D         (d),
    .din_digit (din_digit),
    .Q         (q),
    .shift_out (shift_out),
    .carry     (carry),
    .err       (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_state(input logic [W-1:0] eq, input logic [3:0] eso,
                              input logic ec, input logic ee);
    exp_q.push_back({eq, eso, ec, ee});
  endtask

  task automatic check_state(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got Q=%0h", tag, q);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".Q"},         32'(q),         32'(e[EW-1 -: W]));
      check({tag, ".shift_out"}, 32'(shift_out), 32'(e[5:2]));
      check({tag, ".carry"},     32'(carry),     32'(e[1]));
      check({tag, ".err"},       32'(err),       32'(e[0]));
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic ven, input logic [2:0] vmode,
                       input logic [W-1:0] vd, input logic [3:0] vdin);
    @(negedge clk);
    en        = ven;
    mode      = vmode;
    d         = vd;
    din_digit = vdin;
  endtask

  task automatic step(input string tag, input logic ven, input logic [2:0] vmode,
                      input logic [W-1:0] vd, input logic [3:0] vdin,
                      input logic [W-1:0] eq, input logic [3:0] eso,
                      input logic ec, input logic ee);
    drive(ven, vmode, vd, vdin);
    expect_state(eq, eso, ec, ee);
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic [3:0]   din;
    logic [W-1:0] q;
    logic [3:0]   so;
    logic         c;
    logic         e;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ven, input logic [2:0] vmode,
                              input logic [W-1:0] vd, input logic [3:0] vdin,
                              input logic [W-1:0] eq, input logic [3:0] eso,
                              input logic ec, input logic ee);
    vec_t v;
    v.en = ven; v.mode = vmode; v.d = vd; v.din = vdin;
    v.q = eq; v.so = eso; v.c = ec; v.e = ee;
    return v;
  endfunction

  initial begin
    // Reset asserted from time zero.
    rst = 1'b1; en = 1'b0; mode = MODE_HOLD; d = '0; din_digit = '0;

    //                 en    mode        D        din    Q        so     c     e
    vecs.push_back(mk(1'b1, MODE_LOAD,  12'h199, 4'h0, 12'h199, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_INC,   12'h000, 4'h0, 12'h200, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_LOAD,  12'h999, 4'h0, 12'h999, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_INC,   12'h000, 4'h0, 12'h000, 4'h0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, MODE_HOLD,  12'h000, 4'h0, 12'h000, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_LOAD,  12'h100, 4'h0, 12'h100, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_DEC,   12'h000, 4'h0, 12'h099, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_LOAD,  12'h000, 4'h0, 12'h000, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_DEC,   12'h000, 4'h0, 12'h999, 4'h0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, MODE_DEC,   12'h000, 4'h0, 12'h998, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_LOAD,  12'h123, 4'h0, 12'h123, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_LOAD,  12'h1A3, 4'h0, 12'h123, 4'h0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, MODE_INC,   12'h000, 4'h0, 12'h124, 4'h0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, MODE_CLEAR, 12'h000, 4'h0, 12'h000, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_LOAD,  12'h123, 4'h0, 12'h123, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_SHL,   12'h000, 4'h7, 12'h237, 4'h1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_SHR,   12'h000, 4'h5, 12'h523, 4'h7, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_SHL,   12'h000, 4'hC, 12'h523, 4'h7, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, MODE_SHR,   12'h000, 4'h0, 12'h052, 4'h3, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, MODE_CLEAR, 12'h000, 4'h0, 12'h000, 4'h3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_LOAD,  12'h999, 4'h0, 12'h999, 4'h3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, MODE_INC,   12'h000, 4'h0, 12'h999, 4'h3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, MODE_INC,   12'h000, 4'h0, 12'h999, 4'h3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, MODE_INC,   12'h000, 4'h0, 12'h999, 4'h3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_RSVD,  12'h555, 4'h0, 12'h999, 4'h3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_LOAD,  12'h9A9, 4'h0, 12'h999, 4'h3, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, MODE_RSVD,  12'h000, 4'h0, 12'h999, 4'h3, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, MODE_CLEAR, 12'h000, 4'h0, 12'h999, 4'h3, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, MODE_CLEAR, 12'h000, 4'h0, 12'h000, 4'h3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, MODE_LOAD,  12'hA00, 4'h0, 12'h000, 4'h3, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, MODE_INC,   12'h000, 4'h0, 12'h001, 4'h3, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, MODE_DEC,   12'h000, 4'h0, 12'h000, 4'h3, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, MODE_DEC,   12'h000, 4'h0, 12'h999, 4'h3, 1'b1, 1'b1));

    // Reset state while rst is held, before any clock edge matters.
    #2;
    expect_state(12'h000, 4'h0, 1'b0, 1'b0);
    check_state("reset_init");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step($sformatf("v%0d", i), vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].din,
           vecs[i].q, vecs[i].so, vecs[i].c, vecs[i].e);
    end

    // Asynchronous reset between edges after loading 0x456 (err is still set).
    step("ar_load", 1'b1, MODE_LOAD, 12'h456, 4'h0, 12'h456, 4'h3, 1'b0, 1'b1);
    #2;
    rst = 1'b1; en = 1'b0;
    #1;
    expect_state(12'h000, 4'h0, 1'b0, 1'b0);
    check_state("ar_mid");
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset while the wrap pulse is high.
    step("ar_l999", 1'b1, MODE_LOAD, 12'h999, 4'h0, 12'h999, 4'h0, 1'b0, 1'b0);
    step("ar_wrap", 1'b1, MODE_INC,  12'h000, 4'h0, 12'h000, 4'h0, 1'b1, 1'b0);
    step("ar_shl",  1'b1, MODE_SHL,  12'h000, 4'h8, 12'h008, 4'h0, 1'b0, 1'b0);
    step("ar_err",  1'b1, MODE_LOAD, 12'hFFF, 4'h0, 12'h008, 4'h0, 1'b0, 1'b1);
    step("ar_l999b",1'b1, MODE_LOAD, 12'h999, 4'h0, 12'h999, 4'h0, 1'b0, 1'b1);
    step("ar_wrapb",1'b1, MODE_INC,  12'h000, 4'h0, 12'h000, 4'h0, 1'b1, 1'b1);
    #2;
    rst = 1'b1; en = 1'b1; mode = MODE_LOAD; d = 12'h777;
    #1;
    expect_state(12'h000, 4'h0, 1'b0, 1'b0);
    check_state("ar_pulse");
    // rst still high across a clock edge with a pending load: stays reset.
    @(posedge clk);
    #1;
    expect_state(12'h000, 4'h0, 1'b0, 1'b0);
    check_state("ar_hold");
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    step("post_rst", 1'b1, MODE_LOAD, 12'h777, 4'h0, 12'h777, 4'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_reg_n.md
Name: bcd_reg_n

Overview:
Parametrised N-digit packed-BCD register. It is the successor to the fixed-width stacked 4-bit registers used in the BCD adder datapath. Besides hold and parallel load, it supports clear, digit shift left/right with serial digit in/out, and BCD increment/decrement with wrap and carry/borrow. Inputs are checked for BCD validity, and invalid data is rejected and flagged. It serves as the operand/accumulator store around the BCD adder.

Parameters:
DIGITS, 3, number of BCD digits (1..8); data width W = 4*DIGITS
RESET_VAL, 0, packed-BCD reset/clear value; every nibble must be 0..9 (elaboration check, fatal otherwise)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
en  input  1  operation enable; 0 = hold regardless of mode
mode  input  3  operation select (see Behaviour)
D  input  W  parallel load data, packed BCD, digit 0 in D[3:0]
din_digit  input  4  serial digit inserted on shifts
Q  output  W  registered value
shift_out  output  4  digit shifted out by the last shift
carry  output  1  one-cycle pulse: last edge wrapped on INC/DEC
err  output  1  sticky invalid-input flag

Behaviour:
- One clock; reset is asynchronous and active-high on rst. While rst=1: Q=RESET_VAL, shift_out=0, carry=0, err=0, applied immediately and not waiting for a clock edge. This includes reset in the middle of any operation.
- All outputs are registered. Every operation has a latency of one clock edge; Q reflects the result after the edge at which en=1 was sampled.
- Priority: rst > en=0 > mode.
- en=0: Q, shift_out and err hold; carry=0.
- Mode encoding: 0 HOLD, 1 LOAD, 2 CLEAR, 3 SHL, 4 SHR, 5 INC, 6 DEC, 7 reserved. Reserved behaves as HOLD, and err is not set.
- HOLD: Q holds.
- LOAD: if every nibble of D is 0..9, then Q=D. Otherwise Q holds and err is set to 1.
- CLEAR: Q=RESET_VAL and err=0. This is the only non-reset way to clear err.
- SHL: Q = {Q digits DIGITS-2..0, din_digit}, and shift_out = old digit DIGITS-1.
- SHR: Q = {din_digit, Q digits DIGITS-1..1}, and shift_out = old digit 0.
- Shift with invalid din_digit (>9): Q and shift_out hold, and err is set.
- When DIGITS=1, a shift replaces the digit and outputs the old one.
- INC: BCD +1 via a per-digit ripple carry. A digit equal to 9 with carry-in becomes 0 and propagates carry. All-9s wraps to all-0s and sets carry=1 for exactly one cycle.
- DEC: BCD -1 with borrow. A digit equal to 0 with borrow-in becomes 9. All-0s wraps to all-9s and sets carry=1 for one cycle.
- carry is recomputed on every edge: it is 1 only if that edge performed a wrapping INC/DEC, and 0 otherwise. This includes back-to-back non-wrapping operations.
- Q can only hold valid BCD, because loads and shifts are guarded. INC/DEC therefore never see invalid digits.
- err sets in the same edge as the rejected operation and stays set through later valid operations until CLEAR or rst.

Decomposition:
- Shared package/header bcd_pkg: mode constants (MODE_HOLD..MODE_DEC), BCD digit width constant 4, and function is_bcd_digit.
- One natural sub-module, bcd_digit_cell: combinational per-digit inc/dec with carry/borrow in and out. It is instantiated DIGITS times in a generate loop.
- All state (Q, shift_out, carry, err) lives in bcd_reg_n.

Test Plan:
- DIGITS=3. Load 0x456, then assert rst asynchronously between edges -> Q=0x000, carry=0, err=0 before the next edge.
- LOAD 0x199 then INC -> Q=0x200, carry=0. LOAD 0x999 then INC -> Q=0x000 with carry=1 for one cycle. A following HOLD gives carry=0.
- LOAD 0x100 then DEC -> Q=0x099. LOAD 0x000 then DEC -> Q=0x999, carry=1.
- LOAD 0x123. LOAD 0x1A3 -> Q stays 0x123, err=1. INC -> Q=0x124 with err still 1. CLEAR -> Q=0x000, err=0.
- Q=0x123. SHL with din_digit=7 -> Q=0x237, shift_out=1. SHR with din_digit=5 -> Q=0x523, shift_out=7. SHL with din_digit=0xC -> Q holds, err=1.
- Q=0x999, en=0, mode=INC for 3 cycles -> Q=0x999 held, carry=0. mode=7 with en=1 -> hold, err unchanged.
